// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg
// Shared definitions for the memory-mapped bus timer: default window base,
// word offsets of the registers inside the 32-byte window, and the bit
// positions inside the TCON control/status register.
// No ports (package only).
package bus_timer_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'h4000_0000;

  // Word index inside the window, i.e. Address[4:2].
  localparam logic [2:0] OFF_TH   = 3'd0;  // byte offset 0x00
  localparam logic [2:0] OFF_TL   = 3'd1;  // byte offset 0x04
  localparam logic [2:0] OFF_TCON = 3'd2;  // byte offset 0x08
  localparam logic [2:0] OFF_PSC  = 3'd6;  // byte offset 0x18

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  localparam int PSC_W = 16;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler
// Divides the clock into count ticks. The internal counter runs while the
// timer is enabled and emits a tick when it equals the programmed PSC
// value, then wraps to 0; a PSC of 0 therefore ticks every enabled cycle.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   en     in   timer enable; counter is held at 0 while low
//   psc    in   prescale compare value
//   clear  in   zeroes the counter (asserted on a PSC write)
//   tick   out  combinational count-enable for the timer counter
module timer_prescaler
  import bus_timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  input  logic             clear,
  output logic             tick
);

  logic [PSC_W-1:0] count;

  assign tick = en && (count == psc);

  // Prescale counter: held at zero when disabled or cleared, otherwise
  // counts up and wraps to zero on the cycle that produces a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !en) begin
      count <= '0;
    end else if (count == psc) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// bus_timer
// Memory-mapped timer responder on the CPU data bus. Decodes word loads and
// stores inside a 32-byte window at BASE, holds the reload (TH), counter (TL)
// and control/status (TCON) registers, counts, and raises a registered level
// interrupt when the counter wraps with interrupts enabled.
// Optional feature macro: BUS_TIMER_PRESCALE_EN adds a 16-bit PSC register at
// offset 0x18 and the timer_prescaler sub-module.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   MemRead     in   load strobe
//   MemWrite    in   store strobe
//   Address     in   byte address, bits [1:0] ignored
//   Write_data  in   store data
//   Read_data   out  registered load data, valid the cycle after the load
//   irq         out  registered level interrupt request (IE & ST)
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE = DEFAULT_BASE
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        irq
);

  logic [31:0] th;
  logic [31:0] tl;
  logic        en;
  logic        ie;
  logic        st;
  logic        tick;
  logic        in_window;
  logic [2:0]  offset;
  logic        wr_th;
  logic        wr_tl;
  logic        wr_tcon;
  logic        overflow;
  logic [31:0] read_value;
  logic        unused_addr;

  assign unused_addr = ^Address[1:0];

  assign in_window = (Address[31:5] == BASE[31:5]);
  assign offset    = Address[4:2];
  assign wr_th     = MemWrite && in_window && (offset == OFF_TH);
  assign wr_tl     = MemWrite && in_window && (offset == OFF_TL);
  assign wr_tcon   = MemWrite && in_window && (offset == OFF_TCON);

  // A store to TL in a tick cycle takes precedence, so that cycle neither
  // increments nor wraps.
  assign overflow  = tick && !wr_tl && (tl == 32'hFFFF_FFFF);

`ifdef BUS_TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc;
  logic             wr_psc;

  assign wr_psc = MemWrite && in_window && (offset == OFF_PSC);

  // Prescale compare register; writing it also restarts the prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc <= '0;
    end else if (wr_psc) begin
      psc <= Write_data[PSC_W-1:0];
    end
  end

  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .psc   (psc),
    .clear (wr_psc),
    .tick  (tick)
  );
`else
  assign tick = en;
`endif

  // Reload register. On a wrap the counter loads the value TH holds before
  // this edge, so a simultaneous TH store only affects the next wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th <= '0;
    end else if (wr_th) begin
      th <= Write_data;
    end
  end

  // Counter: bus store beats counting; on a tick it increments, or reloads
  // from TH when it is already all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tl <= '0;
    end else if (wr_tl) begin
      tl <= Write_data;
    end else if (overflow) begin
      tl <= th;
    end else if (tick) begin
      tl <= tl + 32'd1;
    end
  end

  // Control and status. ST is write-1-to-clear, and a wrap in the same cycle
  // as the clear keeps ST set so no interrupt is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en <= 1'b0;
      ie <= 1'b0;
      st <= 1'b0;
    end else begin
      if (wr_tcon) begin
        en <= Write_data[TCON_EN];
        ie <= Write_data[TCON_IE];
      end
      if (overflow) begin
        st <= 1'b1;
      end else if (wr_tcon && Write_data[TCON_ST]) begin
        st <= 1'b0;
      end
    end
  end

  // Read mux over the current (pre-store) register values; unmapped
  // offsets inside the window read as zero.
  always_comb begin
    read_value = '0;
    case (offset)
      OFF_TH:   read_value = th;
      OFF_TL:   read_value = tl;
      OFF_TCON: read_value = {29'd0, st, ie, en};
`ifdef BUS_TIMER_PRESCALE_EN
      OFF_PSC:  read_value = {{(32-PSC_W){1'b0}}, psc};
`endif
      default:  read_value = '0;
    endcase
  end

  // Registered load data; loads outside the window leave it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Read_data <= '0;
    end else if (MemRead && in_window) begin
      Read_data <= read_value;
    end
  end

  // Interrupt request lags ST by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= ie && st;
    end
  end

endmodule
